// File: rtl/rom_scan_ctrl_pkg.sv
// Shared types and constants for the ROM scan sequencer and its serial BCD converter.
package rom_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } scan_state_t;

    localparam int         BCD_DIGITS  = 4;
    localparam int         BCD_W       = 4 * BCD_DIGITS;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // Pre-shift correction: a digit of 5 or more would exceed 9 once doubled.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        return (nib >= ADD3_THRESH) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/rom_scan_ctrl_bcd_dd_step.sv
// One combinational double-dabble iteration: add-3 correction on every digit, then shift
// the scratch left by one with a new binary bit entering at the bottom.
module bcd_dd_step
    import rom_scan_ctrl_pkg::*;
(
    input  logic [BCD_W-1:0] scratch_in,
    input  logic             bit_in,
    output logic [BCD_W-1:0] scratch_out
);

    // The carry out of the top digit is dropped, which is what limits the range to 9999.
    always_comb begin
        logic [3:0] adj;
        logic       carry;
        scratch_out = '0;
        adj         = '0;
        carry       = bit_in;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            adj                   = dd_adjust(scratch_in[4*i +: 4]);
            scratch_out[4*i +: 4] = {adj[2:0], carry};
            carry                 = adj[3];
        end
    end

endmodule

// File: rtl/rom_scan_ctrl.sv
// Lookup ROM sequencer: selects a manual or auto-scanned address, waits out the ROM read
// latency, converts the returned word to BCD serially and holds the digits for display.
module rom_scan_ctrl
    import rom_scan_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 10,
    parameter int ROM_LAT  = 1,
    parameter int ADDR_MAX = 1023
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr_sw,
    input  logic              tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [3:0]        bcd0,
    output logic [3:0]        bcd1,
    output logic [3:0]        bcd2,
    output logic [3:0]        bcd3,
    output logic              valid,
    output logic              busy
);

    localparam int                WCNT_W    = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
    localparam int                ICNT_W    = $clog2(DATA_W + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ADDR_MAX);

    scan_state_t       state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              pending_q, pending_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ICNT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]  scratch_q, scratch_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;

    logic [BCD_W-1:0]  scratch_step;
    logic              launch;
    logic [ADDR_W-1:0] launch_addr;

    bcd_dd_step u_dd_step (
        .scratch_in  (scratch_q),
        .bit_in      (shift_q[DATA_W-1]),
        .scratch_out (scratch_step)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            last_addr_q <= '1;
            pending_q   <= 1'b0;
            wait_cnt_q  <= '0;
            iter_cnt_q  <= '0;
            shift_q     <= '0;
            scratch_q   <= '0;
            bcd_q       <= '0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            last_addr_q <= last_addr_d;
            pending_q   <= pending_d;
            wait_cnt_q  <= wait_cnt_d;
            iter_cnt_q  <= iter_cnt_d;
            shift_q     <= shift_d;
            scratch_q   <= scratch_d;
            bcd_q       <= bcd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        last_addr_d = last_addr_q;
        pending_d   = pending_q;
        wait_cnt_d  = wait_cnt_q;
        iter_cnt_d  = iter_cnt_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        bcd_d       = bcd_q;
        launch      = 1'b0;
        launch_addr = rom_addr_q;

        // Only one tick can be remembered while a conversion is running.
        if (!mode) begin
            pending_d = 1'b0;
        end else if (tick && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!mode) begin
                    if (addr_sw != last_addr_q) begin
                        launch      = 1'b1;
                        launch_addr = addr_sw;
                    end
                end else if (tick || pending_q) begin
                    launch      = 1'b1;
                    launch_addr = (rom_addr_q == ADDR_LAST) ? '0 : rom_addr_q + ADDR_W'(1);
                end
                if (launch) begin
                    rom_addr_d  = launch_addr;
                    last_addr_d = launch_addr;
                    wait_cnt_d  = '0;
                    pending_d   = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WCNT_W'(ROM_LAT)) begin
                    shift_d    = rom_q;
                    scratch_d  = '0;
                    iter_cnt_d = '0;
                    state_d    = ST_CONV;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ST_CONV: begin
                scratch_d  = scratch_step;
                shift_d    = shift_q << 1;
                iter_cnt_d = iter_cnt_q + ICNT_W'(1);
                // Digits are published only from the last iteration, never part-way.
                if (iter_cnt_q == ICNT_W'(DATA_W - 1)) begin
                    bcd_d   = scratch_step;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rom_addr = rom_addr_q;
    assign bcd0     = bcd_q[3:0];
    assign bcd1     = bcd_q[7:4];
    assign bcd2     = bcd_q[11:8];
    assign bcd3     = bcd_q[15:12];
    assign valid    = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/rom_scan_ctrl.md
Name: rom_scan_ctrl

Overview:
Sequencer between the switch/tick inputs, the synchronous lookup ROM and the 7-segment decoders. It drives the ROM address in one of two modes: manual (switch value) or auto-scan (address advances on a pacing tick). It waits out the ROM read latency, then converts the ROM word to BCD serially with a shift-add-3 (double-dabble) loop. It holds the resulting digits stable for the hex_to_7seg decoders until the next conversion completes.

Parameters:
ADDR_W, 10, ROM address width
DATA_W, 10, ROM data width; converted value range 0..2^DATA_W-1
ROM_LAT, 1, ROM read latency in clock cycles (>=1)
ADDR_MAX, 1023, last address visited in auto-scan before wrapping to 0

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
RESET_N  input  1  asynchronous active-low reset
mode  input  1  0 = manual (addr_sw), 1 = auto-scan
addr_sw  input  ADDR_W  manual address
tick  input  1  one-cycle pacing pulse for auto-scan
rom_addr  output  ADDR_W  registered address to ROM
rom_q  input  DATA_W  ROM read data
bcd0..bcd3  output  4 each  ones..thousands digits
valid  output  1  one-cycle pulse when bcd0..bcd3 update
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, RESET_N low): state IDLE, rom_addr=0, bcd0..3=0, valid=0, busy=0, pending=0, last_addr = all ones (forces a first manual conversion).
- FSM states: IDLE, WAIT, CONV, DONE.
- Trigger in IDLE, one of:
  - manual: addr_sw != last_addr; A = addr_sw.
  - auto: tick=1 or pending=1; A = rom_addr+1, or 0 if rom_addr==ADDR_MAX.
- Launch at edge k: rom_addr<=A, last_addr<=A, wait count cleared, pending cleared, go to WAIT.
- WAIT: lasts ROM_LAT cycles. At edge k+ROM_LAT+1, rom_q is loaded into the shift register, the BCD scratch (4 digits) is cleared, and the FSM goes to CONV.
- CONV: DATA_W iterations, one per cycle. Each iteration adds 3 to every scratch nibble >=5, then shifts the {scratch, shift} pair left by 1.
- At the final CONV edge (k+ROM_LAT+DATA_W+1): bcd0..3 take the scratch digits and the FSM goes to DONE. valid=1 only during the DONE cycle. DONE always returns to IDLE on the next edge.
- Latency with defaults: launch edge to bcd update is 12 edges. Back-to-back launches are spaced by ROM_LAT+DATA_W+3 cycles.
- bcd0..3 never change except at the final CONV edge; no intermediate values are visible.
- tick while busy in auto mode sets pending (one deep); further ticks while pending=1 are dropped. pending is serviced from IDLE on the cycle after DONE.
- tick is ignored in manual mode. pending is cleared whenever mode=0.
- A mode change mid-conversion does not abort it. The new mode applies at the next IDLE.
- addr_sw changes during a conversion are not sampled. They are detected at IDLE against last_addr.
- Auto-scan wrap: rom_addr==ADDR_MAX then tick gives 0. Values above ADDR_MAX are reachable only via manual mode.
- Values > 9999 cannot occur for DATA_W<=13. For DATA_W>13, digits above the thousands are discarded (documented limit).
- Reset asserted in any state aborts immediately to reset values; no partial digits survive.

Decomposition:
- Shared package: FSM state encoding (IDLE/WAIT/CONV/DONE), BCD digit count localparam (4), the add-3 threshold constant (5).
- One natural sub-module: bcd_dd_step. Combinational single double-dabble iteration (4-digit scratch + 1 input bit in, next scratch out), reusable by other serial converters. Counters and FSM stay in rom_scan_ctrl.

Test Plan:
- Manual, ROM model q=addr: after reset, addr_sw=1023 -> rom_addr=1023 at launch edge; 12 edges later bcd3..0=1,0,2,3, valid high exactly 1 cycle, busy low after.
- Manual, no change: addr_sw held at 57 after conversion -> no further launch, valid stays 0 for 100 cycles, bcd=0,0,5,7.
- Auto-scan wrap, ADDR_MAX=1023, rom_addr=1023, q=1023-addr: tick -> rom_addr=0, bcd=1,0,2,3; next tick -> rom_addr=1, bcd=1,0,2,2.
- Tick overrun: three ticks during one conversion -> exactly one extra launch, starting the cycle after DONE; total 2 valid pulses, rom_addr advanced by 2.
- Reset mid-CONV (6th iteration) -> same cycle: bcd0..3=0, rom_addr=0, busy=0, valid=0; after release, first manual conversion of addr_sw=0 gives bcd=0,0,0,0 with one valid pulse.
- ROM_LAT=3 variant, q=addr, addr_sw=999 -> bcd=0,9,9,9 at launch+14 edges; data sampled only after the third wait cycle (the bench drives garbage on rom_q earlier).
